// File: rtl/adc_spi_responder_if.sv
// ADS4128-style configuration pins between the CW_ADC_CTRL bit-bang master and the ADC side.
interface adc_spi_responder_if;
    logic adc_reset_i;
    logic adc_sen_i;
    logic adc_sclk_i;
    logic adc_sdata_i;
    logic adc_sdout_o;

    modport master (
        output adc_reset_i,
        output adc_sen_i,
        output adc_sclk_i,
        output adc_sdata_i,
        input  adc_sdout_o
    );

    modport slave (
        input  adc_reset_i,
        input  adc_sen_i,
        input  adc_sclk_i,
        input  adc_sdata_i,
        output adc_sdout_o
    );
endinterface

// File: rtl/adc_spi_responder.sv
// ADS4128 configuration-port responder: register file with 16-bit address/data
// write frames and SDOUT readback when reg[0] bit 0 selects readout mode.
module adc_spi_responder #(
    parameter int unsigned pREG_DEPTH   = 64,
    parameter int unsigned pSYNC_STAGES = 2
) (
    input  logic                  clk_usb,
    input  logic                  reset_i,
    adc_spi_responder_if.slave    adc,
    input  logic                  adc_ovr_i,
    output logic                  readout_o,
    output logic                  wr_strobe_o,
    output logic [7:0]            wr_addr_o,
    output logic [7:0]            wr_data_o,
    input  logic [7:0]            peek_addr_i,
    output logic [7:0]            peek_data_o,
    output logic [7:0]            frame_err_cnt_o
);
    localparam int unsigned AW     = $clog2(pREG_DEPTH);
    localparam logic [8:0]  DEPTH9 = 9'(pREG_DEPTH);

    typedef enum logic [1:0] {IDLE, ADDR, DATA, DONE} state_t;

    function automatic logic in_range(input logic [7:0] a);
        return {1'b0, a} < DEPTH9;
    endfunction

    logic [pSYNC_STAGES-1:0] sen_sync, sclk_sync, sdata_sync, rst_sync, ovr_sync;
    logic sen_s, sclk_s, sdata_s, rst_s, ovr_s, sclk_d, fe;

    logic [7:0] regs [pREG_DEPTH];

    state_t     state, state_n;
    logic [4:0] cnt, cnt_n;
    logic [7:0] sh, sh_n, sh_in;
    logic [7:0] addr_q, addr_n;
    logic [7:0] rd_sh, rd_sh_n;
    logic       rd_act, rd_act_n;
    logic       abort_q, abort_n;
    logic       sdout_q, sdout_n;
    logic       wr_strobe_q;
    logic [7:0] wr_addr_q, wr_addr_n, wr_data_q, wr_data_n;
    logic [7:0] err_q;
    logic       err_inc, do_write, do_clear;

    always_ff @(posedge clk_usb or posedge reset_i) begin
        if (reset_i) begin
            sen_sync   <= '1;
            sclk_sync  <= '1;
            sdata_sync <= '0;
            rst_sync   <= '0;
            ovr_sync   <= '0;
            sclk_d     <= 1'b1;
        end else begin
            sen_sync   <= {sen_sync[pSYNC_STAGES-2:0],   adc.adc_sen_i};
            sclk_sync  <= {sclk_sync[pSYNC_STAGES-2:0],  adc.adc_sclk_i};
            sdata_sync <= {sdata_sync[pSYNC_STAGES-2:0], adc.adc_sdata_i};
            rst_sync   <= {rst_sync[pSYNC_STAGES-2:0],   adc.adc_reset_i};
            ovr_sync   <= {ovr_sync[pSYNC_STAGES-2:0],   adc_ovr_i};
            sclk_d     <= sclk_s;
        end
    end

    assign sen_s   = sen_sync[pSYNC_STAGES-1];
    assign sclk_s  = sclk_sync[pSYNC_STAGES-1];
    assign sdata_s = sdata_sync[pSYNC_STAGES-1];
    assign rst_s   = rst_sync[pSYNC_STAGES-1];
    assign ovr_s   = ovr_sync[pSYNC_STAGES-1];
    assign fe      = sclk_d & ~sclk_s;
    assign sh_in   = {sh[6:0], sdata_s};

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        sh_n      = sh;
        addr_n    = addr_q;
        rd_sh_n   = rd_sh;
        rd_act_n  = rd_act;
        abort_n   = abort_q;
        wr_addr_n = wr_addr_q;
        wr_data_n = wr_data_q;
        err_inc   = 1'b0;
        do_write  = 1'b0;
        do_clear  = 1'b0;
        if (rst_s) begin
            // abort_q keeps a frame that was cut by ADC_RESET from restarting mid-way
            do_clear = 1'b1;
            state_n  = IDLE;
            cnt_n    = '0;
            rd_act_n = 1'b0;
            abort_n  = 1'b1;
        end else if (sen_s) begin
            state_n  = IDLE;
            cnt_n    = '0;
            rd_act_n = 1'b0;
            abort_n  = 1'b0;
            if (cnt != 5'd0 && cnt != 5'd16)
                err_inc = 1'b1;
        end else begin
            unique case (state)
                IDLE: if (!abort_q) begin
                    state_n = ADDR;
                    cnt_n   = '0;
                end
                ADDR: if (fe) begin
                    sh_n  = sh_in;
                    cnt_n = cnt + 5'd1;
                    if (cnt == 5'd7) begin
                        addr_n  = sh_in;
                        state_n = DATA;
                        if (readout_o && sh_in != 8'd0) begin
                            rd_act_n = 1'b1;
                            rd_sh_n  = in_range(sh_in) ? regs[sh_in[AW-1:0]] : '0;
                        end
                    end
                end
                DATA: if (fe) begin
                    sh_n  = sh_in;
                    cnt_n = cnt + 5'd1;
                    if (rd_act)
                        rd_sh_n = {rd_sh[6:0], 1'b0};
                    if (cnt == 5'd15) begin
                        state_n = DONE;
                        if (!readout_o || addr_q == 8'd0) begin
                            do_write  = 1'b1;
                            wr_addr_n = addr_q;
                            wr_data_n = sh_in;
                        end
                    end
                end
                DONE: if (fe) err_inc = 1'b1;
                default: state_n = IDLE;
            endcase
        end
        sdout_n = rd_act_n ? rd_sh_n[7] : ovr_s;
    end

    always_ff @(posedge clk_usb or posedge reset_i) begin
        if (reset_i) begin
            state       <= IDLE;
            cnt         <= '0;
            sh          <= '0;
            addr_q      <= '0;
            rd_sh       <= '0;
            rd_act      <= 1'b0;
            abort_q     <= 1'b0;
            sdout_q     <= 1'b0;
            wr_strobe_q <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
            err_q       <= '0;
        end else begin
            state       <= state_n;
            cnt         <= cnt_n;
            sh          <= sh_n;
            addr_q      <= addr_n;
            rd_sh       <= rd_sh_n;
            rd_act      <= rd_act_n;
            abort_q     <= abort_n;
            sdout_q     <= sdout_n;
            wr_strobe_q <= do_write;
            wr_addr_q   <= wr_addr_n;
            wr_data_q   <= wr_data_n;
            if (err_inc && err_q != 8'hFF)
                err_q <= err_q + 8'd1;
        end
    end

    always_ff @(posedge clk_usb or posedge reset_i) begin
        if (reset_i) begin
            for (int unsigned i = 0; i < pREG_DEPTH; i++)
                regs[AW'(i)] <= '0;
        end else if (do_clear) begin
            for (int unsigned i = 0; i < pREG_DEPTH; i++)
                regs[AW'(i)] <= '0;
        end else if (do_write && in_range(wr_addr_n)) begin
            regs[wr_addr_n[AW-1:0]] <= wr_data_n;
        end
    end

    assign readout_o       = regs[0][0];
    assign peek_data_o     = in_range(peek_addr_i) ? regs[peek_addr_i[AW-1:0]] : '0;
    assign adc.adc_sdout_o = sdout_q;
    assign wr_strobe_o     = wr_strobe_q;
    assign wr_addr_o       = wr_addr_q;
    assign wr_data_o       = wr_data_q;
    assign frame_err_cnt_o = err_q;
endmodule

// File: tb/tb_adc_spi_responder.sv
// Directed bench for adc_spi_responder: bit-banged frames against a frame-level register/error model.
module tb_adc_spi_responder;
    localparam int unsigned DEPTH = 64;
    localparam int unsigned SYNC  = 2;

    logic       clk_usb = 1'b0;
    logic       reset_i = 1'b1;
    logic       adc_ovr_i = 1'b0;
    logic       readout_o, wr_strobe_o;
    logic [7:0] wr_addr_o, wr_data_o, peek_data_o, frame_err_cnt_o;
    logic [7:0] peek_addr_i = 8'd0;

    adc_spi_responder_if bus ();

    adc_spi_responder #(.pREG_DEPTH(DEPTH), .pSYNC_STAGES(SYNC)) u_dut (
        .clk_usb         (clk_usb),
        .reset_i         (reset_i),
        .adc             (bus),
        .adc_ovr_i       (adc_ovr_i),
        .readout_o       (readout_o),
        .wr_strobe_o     (wr_strobe_o),
        .wr_addr_o       (wr_addr_o),
        .wr_data_o       (wr_data_o),
        .peek_addr_i     (peek_addr_i),
        .peek_data_o     (peek_data_o),
        .frame_err_cnt_o (frame_err_cnt_o)
    );

    always #5 clk_usb = ~clk_usb;

    int          checks = 0;
    int          failures = 0;
    int          strobe_cnt = 0;
    bit          quiet = 1'b0;
    logic [7:0]  mmem [256];
    int          err_m = 0;
    logic [15:0] exp_q [$];
    logic [7:0]  rd;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    // Compare process: write events every cycle, settled state whenever the bus is quiet.
    initial begin
        forever begin
            @(negedge clk_usb);
            if (!reset_i) begin
                if (wr_strobe_o) begin
                    strobe_cnt++;
                    if (exp_q.size() == 0) begin
                        checks++;
                        failures++;
                        $display("FAIL wr_unexpected actual=%02h/%02h expected=none", wr_addr_o, wr_data_o);
                    end else begin
                        check("wr_event", {wr_addr_o, wr_data_o}, exp_q.pop_front());
                    end
                end
                if (quiet) begin
                    check("readout_model", readout_o, mmem[0][0]);
                    check("err_model", frame_err_cnt_o, err_m);
                    check("peek_model", peek_data_o, mmem[peek_addr_i]);
                end
            end
        end
    end

    task automatic pins(input logic sen, input logic sclk, input logic sdata, input int unsigned cyc);
        bus.adc_sen_i   = sen;
        bus.adc_sclk_i  = sclk;
        bus.adc_sdata_i = sdata;
        repeat (cyc) @(negedge clk_usb);
    endtask

    // nfe falling edges of SCLK inside one SEN-low window; rdo collects SDOUT during the data byte.
    task automatic frame(input logic [15:0] w, input int unsigned nfe, input int unsigned cyc,
                         output logic [7:0] rdo);
        logic [7:0] a, expect_rd;
        logic       writes, reads;
        int         s0;
        a         = w[15:8];
        rdo       = '0;
        quiet     = 1'b0;
        s0        = strobe_cnt;
        writes    = (nfe >= 16) && (!mmem[0][0] || a == 8'd0);
        reads     = (nfe >= 16) && mmem[0][0] && a != 8'd0;
        expect_rd = (int'(a) < DEPTH) ? mmem[a] : 8'd0;
        if (writes) exp_q.push_back(w);
        pins(1'b1, 1'b1, 1'b0, cyc);
        for (int i = 0; i < int'(nfe); i++) begin
            logic b;
            b = (i < 16) ? w[15-i] : 1'b0;
            pins(1'b0, 1'b1, b, cyc);
            if (i >= 8 && i < 16) rdo = {rdo[6:0], bus.adc_sdout_o};
            pins(1'b0, 1'b0, b, cyc);
        end
        pins(1'b1, 1'b1, 1'b0, cyc);
        if (writes && int'(a) < DEPTH) mmem[a] = w[7:0];
        if (nfe > 0 && nfe < 16) err_m = (err_m < 255) ? err_m + 1 : 255;
        if (nfe > 16) err_m = (err_m + int'(nfe) - 16 > 255) ? 255 : err_m + int'(nfe) - 16;
        if (reads) check("read_model", rdo, expect_rd);
        check("strobes_per_frame", strobe_cnt - s0, writes ? 1 : 0);
        check("wr_queue_drained", exp_q.size(), 0);
        quiet = 1'b1;
    endtask

    task automatic peek(input logic [7:0] a, input string name, input logic [7:0] exp);
        @(posedge clk_usb);
        peek_addr_i = a;
        @(negedge clk_usb);
        check(name, peek_data_o, exp);
    endtask

    task automatic sweep();
        for (int a = 0; a < 256; a++) begin
            @(posedge clk_usb);
            peek_addr_i = 8'(a);
        end
        @(negedge clk_usb);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) mmem[i] = 8'd0;
        bus.adc_reset_i = 1'b0;
        bus.adc_sen_i   = 1'b1;
        bus.adc_sclk_i  = 1'b1;
        bus.adc_sdata_i = 1'b0;
        repeat (3) @(negedge clk_usb);
        check("rst_readout", readout_o, 1'b0);
        check("rst_strobe", wr_strobe_o, 1'b0);
        check("rst_wr_addr", wr_addr_o, 8'h00);
        check("rst_wr_data", wr_data_o, 8'h00);
        check("rst_err", frame_err_cnt_o, 8'h00);
        check("rst_sdout", bus.adc_sdout_o, 1'b0);
        reset_i = 1'b0;
        repeat (4) @(negedge clk_usb);
        quiet = 1'b1;

        frame(16'h05AA, 16, 8, rd);
        peek(8'h05, "write_05", 8'hAA);
        check("wr_addr_05", wr_addr_o, 8'h05);
        check("wr_data_AA", wr_data_o, 8'hAA);
        check("err_after_write", frame_err_cnt_o, 8'd0);

        // 17th falling edge lands after the frame completed: write kept, one error
        frame(16'h0711, 17, 8, rd);
        peek(8'h07, "write_07_extra_edge", 8'h11);
        check("err_extra_edge", frame_err_cnt_o, 8'd1);

        frame(16'h0001, 16, 8, rd);
        check("readout_on", readout_o, 1'b1);
        frame(16'h0500, 16, 8, rd);
        check("readback_05", rd, 8'hAA);
        peek(8'h05, "read_keeps_05", 8'hAA);

        frame(16'h0000, 16, 8, rd);
        check("readout_off", readout_o, 1'b0);
        adc_ovr_i = 1'b0;
        repeat (3) @(negedge clk_usb);
        check("sdout_ovr_0", bus.adc_sdout_o, 1'b0);
        adc_ovr_i = 1'b1;
        repeat (3) @(negedge clk_usb);
        check("sdout_ovr_1", bus.adc_sdout_o, 1'b1);
        adc_ovr_i = 1'b0;

        frame(16'h1234, 11, 5, rd);
        check("err_partial", frame_err_cnt_o, 8'd2);
        peek(8'h12, "partial_no_write", 8'h00);
        for (int n = 0; n < 299; n++) frame(16'h1234, 11, 5, rd);
        check("err_saturated", frame_err_cnt_o, 8'd255);

        // ADC_RESET pulse in the middle of a frame
        quiet = 1'b0;
        pins(1'b1, 1'b1, 1'b0, 8);
        for (int i = 0; i < 5; i++) begin
            pins(1'b0, 1'b1, 1'b1, 8);
            pins(1'b0, 1'b0, 1'b1, 8);
        end
        bus.adc_reset_i = 1'b1;
        pins(1'b0, 1'b1, 1'b0, 8);
        bus.adc_reset_i = 1'b0;
        pins(1'b0, 1'b1, 1'b0, 8);
        pins(1'b1, 1'b1, 1'b0, 8);
        for (int i = 0; i < 256; i++) mmem[i] = 8'd0;
        quiet = 1'b1;
        sweep();
        peek(8'h05, "adc_reset_clears_05", 8'h00);
        check("adc_reset_err_kept", frame_err_cnt_o, 8'd255);
        frame(16'h123C, 16, 8, rd);
        peek(8'h12, "write_after_reset", 8'h3C);
        check("err_after_reset_frame", frame_err_cnt_o, 8'd255);

        frame(16'h3F5A, 16, 8, rd);
        peek(8'h3F, "write_last_reg", 8'h5A);
        frame(16'h5077, 16, 8, rd);
        check("wr_addr_oor", wr_addr_o, 8'h50);
        check("wr_data_oor", wr_data_o, 8'h77);
        peek(8'h50, "peek_oor", 8'h00);
        frame(16'h0001, 16, 8, rd);
        frame(16'h5000, 16, 8, rd);
        check("readback_oor", rd, 8'h00);
        frame(16'h3F00, 16, 8, rd);
        check("readback_3F", rd, 8'h5A);
        frame(16'h0000, 16, 8, rd);
        sweep();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/adc_spi_responder.md
Name: adc_spi_responder

Overview:
- Serial-interface responder that models the ADS4128 configuration port (RESET, SEN, SCLK, SDATA, OVR/SDOUT).
- It is the target end of the bit-banged ADC control path driven by the CW_ADC_CTRL register.
- Used as the ADC model in system simulation and as a drop-in ADC-side emulator on loopback/test builds.
- Holds a register file, accepts 16-bit address/data write frames, and serves register readback on SDOUT when readout mode is enabled.

Parameters:
- pREG_DEPTH, 64: number of implemented registers, addresses 0..pREG_DEPTH-1; range 2..256.
- pSYNC_STAGES, 2: synchronizer flops on each pin input; minimum 2.

Ports:
- clk_usb  input  1  sole clock; all logic is on the rising edge.
- reset_i  input  1  asynchronous, active-high reset.
- adc_reset_i  input  1  ADC_RESET pin; active-high register-file reset.
- adc_sen_i  input  1  ADC_SEN pin; frame enable, active low.
- adc_sclk_i  input  1  ADC_SCLK pin.
- adc_sdata_i  input  1  ADC_SDATA pin; serial data in, MSB first.
- adc_ovr_i  input  1  overrange flag, driven on SDOUT when not in readout mode.
- adc_sdout_o  output  1  ADC_OVR_SDOUT pin.
- readout_o  output  1  readout mode, reg[0] bit 0.
- wr_strobe_o  output  1  one-cycle pulse on each register write.
- wr_addr_o  output  8  address of the last write.
- wr_data_o  output  8  data of the last write.
- peek_addr_i  input  8  side-port read address.
- peek_data_o  output  8  combinational reg[peek_addr_i]; 0 when out of range.
- frame_err_cnt_o  output  8  saturating malformed-frame counter.

Behaviour:
- Pin sampling
  - Each pin input passes through pSYNC_STAGES flops.
  - Reset values of the synchronizers: SEN=1, SCLK=1, others 0.
  - Edge detect compares the synchronized SCLK against a one-cycle-delayed copy.
  - Falling-edge detect (fe) asserts pSYNC_STAGES+1 cycles after the pin falls.
  - Timing contract: minimum SCLK high or low time is pSYNC_STAGES+2 clk_usb cycles. Faster SCLK is undefined.
- Reset values on reset_i
  - All registers = 0; state = IDLE; bit count = 0.
  - adc_sdout_o = 0, readout_o = 0, wr_strobe_o = 0, wr_addr_o = 0, wr_data_o = 0, frame_err_cnt_o = 0.
- State machine
  - IDLE
    - Synchronized SEN low → ADDR, bit count = 0.
  - ADDR
    - On fe, shift the synchronized SDATA into the 8-bit shift register and increment the count.
    - After the 8th fe, latch the address and go to DATA.
    - On that same fe, if readout_o=1 and address≠0: load the read register with reg[addr] (0 if addr ≥ pREG_DEPTH). adc_sdout_o shows bit 7 on the next cycle.
  - DATA
    - On each fe, shift SDATA in. If reading, shift the read register left so SDOUT presents D6..D0 in turn.
    - On the 16th fe go to DONE.
    - On that same fe, perform the write if readout_o=0 or addr=0 (address 0 is always writable so readout can be exited).
    - The write is dropped if addr ≥ pREG_DEPTH.
    - wr_strobe_o, wr_addr_o and wr_data_o update on the write cycle even for out-of-range addresses; the strobe still fires.
  - DONE
    - Any further fe while SEN is low: frame error, ignore the edge.
  - Frame end and errors
    - Synchronized SEN high in any state → IDLE on the next cycle.
    - SEN rising with bit count not 0 and not 16: frame error; discard the partial frame with no write.
    - frame_err_cnt_o increments once per error and saturates at 255.
  - Simultaneous SEN rise and fe in the same cycle: SEN wins and the edge is ignored.
- SDOUT mux
  - adc_sdout_o = read-register MSB while in ADDR-complete/DATA/DONE of a readout frame.
  - Otherwise adc_sdout_o = synchronized adc_ovr_i.
  - Registered, so it changes 1 cycle after fe.
- adc_reset_i
  - Synchronized high for ≥1 cycle clears the whole register file (so readout_o=0) and forces IDLE.
  - A frame in progress is aborted and not counted as an error.
  - Frames are ignored while adc_reset_i is high.
- readout_o is a combinational copy of reg[0][0].

Test Plan:
- Write 0xAA to address 0x05 with the 34-step CW_ADC_CTRL bit-bang pattern (41,01,00,11,10,...,41), 8 clocks per step → peek(0x05)=0xAA; one wr_strobe_o with wr_addr_o=0x05, wr_data_o=0xAA; frame_err_cnt_o=0.
- Write 0x01 to 0x00, then read 0x05 using the 01/02 sampling pattern, shifting the SDOUT samples → assembled byte 0xAA; reg[0x05] unchanged; no wr_strobe_o on the read frame.
- In readout mode write 0x00 to address 0x00 → readout_o falls to 0; adc_sdout_o follows adc_ovr_i (toggle it 0→1 and see 1 within 3 cycles).
- Raise SEN after 11 falling edges → no write; frame_err_cnt_o=1. Repeat 300 times → saturates at 255.
- Pulse adc_reset_i mid-frame after 5 edges, then send a full frame → all registers 0 after the pulse; the new frame writes correctly; error count unchanged.
- Write to 0x50 with pREG_DEPTH=64 → wr_strobe_o fires with wr_addr_o=0x50; peek(0x50)=0; a readout of 0x50 returns 0x00.
